// File: rtl/line_draw_sequencer.sv
// line_draw_sequencer: command front-end for the Bresenham line engine.
// Two requesters (host = port 0, shape decomposer = port 1) are arbitrated
// round-robin into a small command FIFO. A sequencer pops one command at a
// time and drives the engine's start / reset_buff / coordinate inputs until
// the engine reports done, or until a watchdog gives up on the command.
module line_draw_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int COORD_W     = 8,
    parameter int TIMEOUT_CYC = 16384
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          req0_valid,
    output logic                          req0_ready,
    input  logic [4*COORD_W:0]            req0_cmd,
    input  logic                          req1_valid,
    output logic                          req1_ready,
    input  logic [4*COORD_W:0]            req1_cmd,
    output logic [COORD_W-1:0]            eng_x0,
    output logic [COORD_W-1:0]            eng_y0,
    output logic [COORD_W-1:0]            eng_x1,
    output logic [COORD_W-1:0]            eng_y1,
    output logic                          eng_start,
    output logic                          eng_reset_buff,
    input  logic                          eng_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          timeout_err
);

    localparam int CMD_W = 4*COORD_W + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        CLR_ASSERT,
        CLR_RELEASE,
        CLR_SETTLE
    } state_t;

    state_t               state;
    logic [CMD_W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    // 1 when port 1 won the most recent transfer, so port 0 is preferred next
    logic                 last_grant;
    logic [TO_W-1:0]      to_cnt;

    logic                 full;
    logic                 empty;
    logic                 grant0;
    logic                 grant1;
    logic                 push;
    logic                 pop;
    logic [CMD_W-1:0]     push_cmd;
    logic [CMD_W-1:0]     head;

    // Full uses the registered count, so a pop in this cycle never frees a slot early.
    assign full       = (count == FULL_COUNT);
    assign empty      = (count == '0);
    assign push       = grant0 | grant1;
    assign pop        = (state == IDLE) && !empty;
    assign push_cmd   = grant1 ? req1_cmd : req0_cmd;
    assign head       = mem[rd_ptr];
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign fifo_count = count;
    assign busy       = (state != IDLE) || !empty;

    // Round-robin grant: a lone requester always wins, a tie goes to the port not served last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!full) begin
            if (req0_valid && (!req1_valid || last_grant)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    // Command storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_cmd;
        end
    end

    // FIFO pointers, occupancy and the arbiter's last-winner memory.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_grant <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                last_grant <= grant1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sequencer: strobes are registered so each is high exactly while its state is current.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state          <= IDLE;
            eng_start      <= 1'b0;
            eng_reset_buff <= 1'b0;
            eng_x0         <= '0;
            eng_y0         <= '0;
            eng_x1         <= '0;
            eng_y1         <= '0;
            to_cnt         <= '0;
            timeout_err    <= 1'b0;
        end else begin
            eng_start      <= 1'b0;
            eng_reset_buff <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        if (head[CMD_W-1]) begin
                            // Clear: coordinates are meaningless, keep the previous ones.
                            eng_reset_buff <= 1'b1;
                            state          <= CLR_ASSERT;
                        end else begin
                            eng_x0    <= head[4*COORD_W-1:3*COORD_W];
                            eng_y0    <= head[3*COORD_W-1:2*COORD_W];
                            eng_x1    <= head[2*COORD_W-1:COORD_W];
                            eng_y1    <= head[COORD_W-1:0];
                            eng_start <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    to_cnt <= '0;
                    state  <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (eng_done) begin
                        state <= IDLE;
                    end else if (to_cnt == TO_LAST) begin
                        // Engine is stuck: drop the command and flag it until reset.
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                CLR_ASSERT: begin
                    // The start pulse here only releases the engine from its clear state.
                    eng_start <= 1'b1;
                    state     <= CLR_RELEASE;
                end
                CLR_RELEASE: begin
                    state <= CLR_SETTLE;
                end
                CLR_SETTLE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
